mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative signed 32-bit multiply/divide unit in the execute stage, beside the ALU and barrel shifters.
//   A one-cycle start pulse launches the operation. The unit then does one shift-and-add or
//   shift-and-subtract step per clock, using fixed 1-bit left/arithmetic-right shifts of its
//   internal accumulator. It raises a one-cycle ready pulse with the result and an exception flag.
//   The pipeline stalls the execute stage while the unit is busy.
// PARAMETERS
//   WIDTH    32   operand/result width; the iteration count equals WIDTH
//   CNT_W    5    iteration counter width, log2(WIDTH)
// PORTS
//   clock           in   1      rising-edge clock
//   reset           in   1      synchronous, active-high reset
//   data_operandA   in   WIDTH  multiplicand / dividend (two's complement)
//   data_operandB   in   WIDTH  multiplier / divisor (two's complement)
//   ctrl_MULT       in   1      start-multiply pulse; operands are sampled on the same edge
//   ctrl_DIV        in   1      start-divide pulse; operands are sampled on the same edge
//   data_result     out  WIDTH  low WIDTH bits of the product, or the quotient
//   data_exception  out  1      overflow, divide-by-zero or INT_MIN/-1
//   data_resultRDY  out  1      one-cycle pulse: result and exception are valid
// BEHAVIOUR
// - Clock and reset: one clock, clock. reset is synchronous and active-high and dominates all other inputs.
//   - On reset: state=IDLE, counter=0.
//   - data_result=0, data_exception=0, data_resultRDY=0.
//   - Reset asserted mid-operation abandons the operation; no ready pulse follows.
// - States: IDLE, MULT, DIV, DONE.
//   - IDLE: ctrl_MULT -> MULT, ctrl_DIV -> DIV. The edge that takes the transition latches both operands and clears the counter.
//   - MULT/DIV: one iteration per edge, counter+1. The edge completing iteration WIDTH (counter==WIDTH-1) moves the state to DONE.
//   - DONE: data_resultRDY=1 for exactly this cycle. The next edge returns to IDLE unless a start is sampled.
// - Latency: start sampled at edge E0; data_resultRDY is high in the cycle after edge E(WIDTH+1).
//   Default WIDTH=32 gives 33 cycles. Latency is fixed for all operand values, including divide-by-zero.
// - Start pulses in any state, including MULT/DIV/DONE, abort the current operation and restart with the
//   new operands. The aborted operation produces no ready pulse.
// - ctrl_MULT and ctrl_DIV both high on the same edge: multiply wins.
// - Multiply: radix-2 Booth on a 2*WIDTH+1-bit accumulator, arithmetic right shift by 1 per step.
//   - data_result = product[WIDTH-1:0].
//   - data_exception=1 when the signed 2*WIDTH-bit product is not the sign extension of product[WIDTH-1:0].
// - Divide: non-restoring division on operand magnitudes, with the sign fixed up in the DONE-entry cycle.
//   - The quotient truncates toward zero; the remainder is discarded.
//   - Divisor=0: result=0, exception=1.
//   - Dividend=INT_MIN (0x80000000) with divisor=-1: result=0x80000000, exception=1.
// - Output registers: data_result and data_exception are registered on the edge entering DONE.
//   They hold until the next start edge or reset. A start edge clears them to 0.
// - data_resultRDY is decoded from state==DONE only. There is no combinational path from the inputs to any output.
// - Operand inputs may change freely after the start edge; only the latched copies are used.
// TESTING
// - Reset, then ctrl_MULT with A=7, B=-3 -> resultRDY pulse exactly 33 cycles later; result=0xFFFFFFEB (-21), exception=0.
// - ctrl_MULT with A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1.
//   ctrl_MULT with A=0x80000000, B=1 -> result=0x80000000, exception=0.
// - ctrl_DIV divide results, all with exception=0:
//   - A=-7, B=2 -> result=0xFFFFFFFD (-3).
//   - A=100, B=7 -> result=14.
//   - A=5, B=9 -> result=0.
// - ctrl_DIV exception cases:
//   - A=12, B=0 -> result=0, exception=1, still 33-cycle latency.
//   - A=0x80000000, B=-1 -> result=0x80000000, exception=1.
// - Restart and priority:
//   - ctrl_MULT (3*4), then 10 cycles later ctrl_DIV (9/3) -> exactly one resultRDY, 33 cycles after the DIV edge, result=3.
//   - ctrl_MULT and ctrl_DIV together with 6,2 -> result=12.
// - Reset asserted at iteration 20 -> outputs 0 on the next edge; no resultRDY within 40 cycles. A new start then completes normally.
//   Back-to-back: start on the DONE cycle -> new result after another 33 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply/divide unit for the execute stage.
//   Multiply uses radix-2 Booth on a 2*WIDTH+1-bit accumulator (one arithmetic
//   right shift per step). Divide uses non-restoring division on operand
//   magnitudes, with the quotient sign fixed up on the edge that enters DONE.
//   A start pulse in any state aborts the current operation and restarts.
//   Latency is fixed: start sampled at edge E0, data_resultRDY high after E(WIDTH+1).
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   data_operandA   multiplicand / dividend (two's complement)
//   data_operandB   multiplier / divisor (two's complement)
//   ctrl_MULT       start-multiply pulse (wins over ctrl_DIV)
//   ctrl_DIV        start-divide pulse
//   data_result     low WIDTH bits of the product, or the quotient
//   data_exception  multiply overflow, divide-by-zero or INT_MIN/-1
//   data_resultRDY  one-cycle pulse while result/exception are fresh
//
// state | meaning
// IDLE  | waiting for a start pulse
// MULT  | one setup edge, then WIDTH Booth iterations
// DIV   | one setup edge, then WIDTH non-restoring iterations
// DONE  | result valid, data_resultRDY high for this cycle
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  localparam logic [WIDTH-1:0] int_min_val = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 primed;   // setup edge done; iterations may run
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH:0]     acc;      // {hi, multiplier/low product, booth q-1}
  logic [WIDTH+1:0]     rem;      // signed partial remainder, 2 guard bits
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     dvs;

  logic [WIDTH:0]       booth_hi;
  logic [WIDTH:0]       booth_sum;
  logic [2*WIDTH:0]     booth_nx;
  logic                 mult_exc;
  logic [WIDTH+1:0]     rem_sh;
  logic [WIDTH+1:0]     rem_nx;
  logic [WIDTH-1:0]     quo_nx;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic                 neg;
  logic                 div_zero;
  logic [WIDTH-1:0]     div_res;
  logic                 div_exc;
  logic                 last_iter;

  always_comb begin
    // High half is sign-extended by one bit so subtracting INT_MIN cannot wrap.
    booth_hi  = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    booth_sum = booth_hi;
    case (acc[1:0])
      2'b01:   booth_sum = booth_hi + {a_q[WIDTH-1], a_q};
      2'b10:   booth_sum = booth_hi - {a_q[WIDTH-1], a_q};
      default: booth_sum = booth_hi;
    endcase
    booth_nx = {booth_sum, acc[WIDTH:1]};
    // product[2W-1:W-1] must be all zeros or all ones to fit in WIDTH bits
    mult_exc = (booth_nx[2*WIDTH:WIDTH] != '0) && (booth_nx[2*WIDTH:WIDTH] != '1);

    rem_sh = {rem[WIDTH:0], quo[WIDTH-1]};
    rem_nx = rem[WIDTH+1] ? (rem_sh + {2'b00, dvs}) : (rem_sh - {2'b00, dvs});
    quo_nx = {quo[WIDTH-2:0], ~rem_nx[WIDTH+1]};

    abs_a    = a_q[WIDTH-1] ? -a_q : a_q;
    abs_b    = b_q[WIDTH-1] ? -b_q : b_q;
    neg      = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    div_zero = (b_q == '0);
    div_res  = div_zero ? '0 : (neg ? -quo_nx : quo_nx);
    // INT_MIN/-1 naturally yields 0x80000000 from the magnitude path; only flag it
    div_exc  = div_zero || ((a_q == int_min_val) && (b_q == '1));

    last_iter = (cnt == CNT_W'(WIDTH-1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      primed         <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      acc            <= '0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      state          <= ctrl_MULT ? MULT : DIV;
      a_q            <= data_operandA;
      b_q            <= data_operandB;
      cnt            <= '0;
      primed         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      case (state)
        MULT: begin
          if (!primed) begin
            acc    <= {{WIDTH{1'b0}}, b_q, 1'b0};
            primed <= 1'b1;
          end else begin
            acc <= booth_nx;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
              state          <= DONE;
              data_result    <= booth_nx[WIDTH:1];
              data_exception <= mult_exc;
            end
          end
        end
        DIV: begin
          if (!primed) begin
            rem    <= '0;
            quo    <= abs_a;
            dvs    <= abs_b;
            primed <= 1'b1;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
              state          <= DONE;
              data_result    <= div_res;
              data_exception <= div_exc;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  localparam int WIDTH = 32;
  localparam int LAT   = 33;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  mult_div_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             exc;
    int               start;
    string            name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors    = 0;
  int   checks    = 0;
  int   rdy_count = 0;
  int   cyc       = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pops one expectation per ready pulse
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      rdy_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: got result=%h exc=%b at cycle %0d, expected no ready",
                 data_result, data_exception, cyc);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (data_result !== mon_e.res) begin
          errors++;
          $display("FAIL %s_result: got %h expected %h", mon_e.name, data_result, mon_e.res);
        end
        checks++;
        if (data_exception !== mon_e.exc) begin
          errors++;
          $display("FAIL %s_exc: got %b expected %b", mon_e.name, data_exception, mon_e.exc);
        end
        checks++;
        if (cyc - mon_e.start != LAT) begin
          errors++;
          $display("FAIL %s_latency: got %0d expected %0d", mon_e.name, cyc - mon_e.start, LAT);
        end
      end
    end
  end

  // Called at a negedge; start is sampled on the following posedge
  task automatic start_op(input logic m, input logic d, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic push,
                          input logic [WIDTH-1:0] er, input logic ee, input string nm);
    exp_t e;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    if (push) begin
      e.res   = er;
      e.exc   = ee;
      e.start = cyc + 1;
      e.name  = nm;
      sb.push_back(e);
    end
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEADBEEF;
    data_operandB = 32'h5A5A5A5A;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", nm, sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic run_op(input logic m, input logic d, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] er,
                        input logic ee, input string nm);
    @(negedge clock);
    start_op(m, d, a, b, 1'b1, er, ee, nm);
    wait_drain(nm);
  endtask

  task automatic check_val(input string nm, input logic [WIDTH-1:0] got,
                           input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    int r0;
    int n;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check_val("reset_result", data_result, 32'h0);
    check_val("reset_exc", {31'b0, data_exception}, 32'h0);
    check_val("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
    reset = 1'b0;

    run_op(1, 0, 32'd7,        -32'sd3,      32'hFFFFFFEB, 1'b0, "mul_7_m3");
    run_op(1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, "mul_ovf");
    run_op(1, 0, 32'h80000000, 32'd1,        32'h80000000, 1'b0, "mul_intmin_1");
    run_op(1, 0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, "mul_intmin_sq");
    run_op(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, "mul_m1_m1");
    run_op(1, 0, -32'sd5,      -32'sd5,      32'd25,       1'b0, "mul_m5_m5");
    run_op(0, 1, -32'sd7,      32'd2,        32'hFFFFFFFD, 1'b0, "div_m7_2");
    run_op(0, 1, 32'd100,      32'd7,        32'd14,       1'b0, "div_100_7");
    run_op(0, 1, 32'd5,        32'd9,        32'd0,        1'b0, "div_5_9");
    run_op(0, 1, 32'd7,        -32'sd2,      32'hFFFFFFFD, 1'b0, "div_7_m2");
    run_op(0, 1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, "div_max_m1");
    run_op(0, 1, 32'd12,       32'd0,        32'd0,        1'b1, "div_by_zero");
    run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_intmin_m1");

    // Restart: aborted multiply must not report
    @(negedge clock);
    start_op(1, 0, 32'd3, 32'd4, 1'b0, '0, 1'b0, "aborted");
    repeat (9) @(negedge clock);
    start_op(0, 1, 32'd9, 32'd3, 1'b1, 32'd3, 1'b0, "restart_div");
    wait_drain("restart_div");

    run_op(1, 1, 32'd6, 32'd2, 32'd12, 1'b0, "both_start");

    // Reset mid-operation abandons it
    @(negedge clock);
    start_op(1, 0, 32'd123, 32'd456, 1'b0, '0, 1'b0, "reset_abort");
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_val("midreset_result", data_result, 32'h0);
    check_val("midreset_exc", {31'b0, data_exception}, 32'h0);
    check_val("midreset_rdy", {31'b0, data_resultRDY}, 32'h0);
    reset = 1'b0;
    r0 = rdy_count;
    repeat (40) @(negedge clock);
    checks++;
    if (rdy_count != r0) begin
      errors++;
      $display("FAIL midreset_no_rdy: got %0d ready pulses expected 0", rdy_count - r0);
    end
    run_op(0, 1, 32'd20, -32'sd3, 32'hFFFFFFFA, 1'b0, "after_reset");

    // Back-to-back: new start issued during the DONE cycle
    @(negedge clock);
    start_op(1, 0, 32'd9, 32'd9, 1'b1, 32'd81, 1'b0, "b2b_first");
    n = 0;
    while (!data_resultRDY && n < 40) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!data_resultRDY) begin
      errors++;
      $display("FAIL b2b_first_timeout: got no ready expected ready within 40 cycles");
    end else begin
      start_op(0, 1, 32'd50, 32'd5, 1'b1, 32'd10, 1'b0, "b2b_second");
    end
    wait_drain("b2b_second");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: got %0d leftover expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
